pipelined_csel_adder: RTL and testbench

Parametrised, pipelined carry-select adder/subtractor for the 8-bit CPU datapath, successor to the fixed 8-bit two-block carry-select adder. Operand width and block size are parameters. Each pipeline stage resolves one carry-select block, so throughput is one operation per cycle. A valid/ready handshake with whole-pipe stall lets the ALU or the future multi-cycle multiplier back-pressure it. It also produces carry, signed-overflow and zero flags for the status register.

---
 rtl/csel_adder_pkg.sv | 17 +
 rtl/csel_block.sv | 36 +++
 rtl/pipelined_csel_adder.sv | 150 +++++++++++++++
 tb/tb_pipelined_csel_adder.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/csel_adder_pkg.sv
// Shared defaults, depth helper and per-stage flag bundle for the pipelined carry-select adder.
package csel_adder_pkg;

    localparam int CSEL_WIDTH = 16;
    localparam int CSEL_BLK   = 4;

    function automatic int nblk(input int width, input int blk);
        return width / blk;
    endfunction

    typedef struct packed {
        logic cout;
        logic a_msb;
        logic b_msb;
    } stage_flags_t;

endpackage

// File: rtl/csel_block.sv
// Combinational BLK-bit carry-select block: two ripple chains (carry-in 0 and 1) and a select mux.
module csel_block #(
    parameter int BLK = 4
) (
    input  logic [BLK-1:0] a,
    input  logic [BLK-1:0] b,
    input  logic           cin,
    output logic [BLK-1:0] sum,
    output logic           cout
);

    logic [BLK:0]   c_lo;
    logic [BLK:0]   c_hi;
    logic [BLK-1:0] s_lo;
    logic [BLK-1:0] s_hi;

    always_comb begin
        c_lo    = '0;
        c_hi    = '0;
        s_lo    = '0;
        s_hi    = '0;
        c_lo[0] = 1'b0;
        c_hi[0] = 1'b1;
        for (int i = 0; i < BLK; i++) begin
            s_lo[i]   = a[i] ^ b[i] ^ c_lo[i];
            c_lo[i+1] = (a[i] & b[i]) | (c_lo[i] & (a[i] ^ b[i]));
            s_hi[i]   = a[i] ^ b[i] ^ c_hi[i];
            c_hi[i+1] = (a[i] & b[i]) | (c_hi[i] & (a[i] ^ b[i]));
        end
    end

    // Both chains settle in parallel; the late-arriving true carry only drives this mux.
    assign sum  = cin ? s_hi : s_lo;
    assign cout = cin ? c_hi[BLK] : c_lo[BLK];

endmodule

// File: rtl/pipelined_csel_adder.sv
// Pipelined carry-select adder/subtractor: each stage resolves one BLK-bit block; whole-pipe stall.
// Define CSEL_ADDER_FLAGS_EN to build the signed-overflow and zero flags (tied to 0 otherwise).
module pipelined_csel_adder
    import csel_adder_pkg::*;
#(
    parameter int WIDTH = CSEL_WIDTH,
    parameter int BLK   = CSEL_BLK
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int NBLK = nblk(WIDTH, BLK);

    logic             advance;
    logic [WIDTH-1:0] b_eff;
    logic             c0;

    // valid/ready: a beat transfers when valid & ready are both high in a cycle. The pipe
    // advances whenever the output slot is empty or being drained; otherwise every stage holds.
    assign advance  = out_ready | ~out_valid;
    assign in_ready = advance;
    assign b_eff    = b ^ {WIDTH{sub}};
    assign c0       = cin ^ sub;

    for (genvar k = 0; k < NBLK; k++) begin : gen_stage
        localparam int LO = k * BLK;
        localparam int HI = LO + BLK;
        // Stage word packs {b_eff[W-1:HI], a[W-1:HI], sum[HI-1:0]} so every bit is consumed.
        localparam int WW = 2 * WIDTH - HI;

        logic [BLK-1:0] blk_a;
        logic [BLK-1:0] blk_b;
        logic [BLK-1:0] blk_s;
        logic           blk_cin;
        logic           blk_cout;
        logic           valid_d;
        logic           valid_q;
        logic           carry;
        logic [WW-1:0]  word_d;
        logic [WW-1:0]  word_q;
`ifdef CSEL_ADDER_FLAGS_EN
        logic           a_msb_d;
        logic           b_msb_d;
        stage_flags_t   flg_q;
        assign carry = flg_q.cout;
`else
        logic           carry_q;
        assign carry = carry_q;
`endif

        if (k == 0) begin : gen_src
            assign blk_a   = a[BLK-1:0];
            assign blk_b   = b_eff[BLK-1:0];
            assign blk_cin = c0;
            assign valid_d = in_valid;
`ifdef CSEL_ADDER_FLAGS_EN
            assign a_msb_d = a[WIDTH-1];
            assign b_msb_d = b_eff[WIDTH-1];
`endif
            if (NBLK == 1) begin : gen_word
                assign word_d = blk_s;
            end else begin : gen_word
                assign word_d = {b_eff[WIDTH-1:BLK], a[WIDTH-1:BLK], blk_s};
            end
        end else begin : gen_src
            logic [2*WIDTH-LO-1:0] prev_w;
            assign prev_w  = gen_stage[k-1].word_q;
            assign blk_a   = prev_w[HI-1:LO];
            assign blk_b   = prev_w[WIDTH+BLK-1:WIDTH];
            assign blk_cin = gen_stage[k-1].carry;
            assign valid_d = gen_stage[k-1].valid_q;
`ifdef CSEL_ADDER_FLAGS_EN
            assign a_msb_d = gen_stage[k-1].flg_q.a_msb;
            assign b_msb_d = gen_stage[k-1].flg_q.b_msb;
`endif
            if (k == NBLK - 1) begin : gen_word
                assign word_d = {blk_s, prev_w[LO-1:0]};
            end else begin : gen_word
                assign word_d = {prev_w[2*WIDTH-LO-1:WIDTH+BLK], prev_w[WIDTH-1:HI],
                                 blk_s, prev_w[LO-1:0]};
            end
        end

        csel_block #(.BLK(BLK)) u_blk (
            .a   (blk_a),
            .b   (blk_b),
            .cin (blk_cin),
            .sum (blk_s),
            .cout(blk_cout)
        );

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                valid_q <= 1'b0;
                word_q  <= '0;
`ifdef CSEL_ADDER_FLAGS_EN
                flg_q   <= '0;
`else
                carry_q <= 1'b0;
`endif
            end else if (advance) begin
                valid_q <= valid_d;
                word_q  <= word_d;
`ifdef CSEL_ADDER_FLAGS_EN
                flg_q   <= {blk_cout, a_msb_d, b_msb_d};
`else
                carry_q <= blk_cout;
`endif
            end
        end
    end

    assign out_valid = gen_stage[NBLK-1].valid_q;
    assign sum       = gen_stage[NBLK-1].word_q;
    assign cout      = gen_stage[NBLK-1].carry;

`ifdef CSEL_ADDER_FLAGS_EN
    logic zero_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            zero_q <= 1'b0;
        end else if (advance) begin
            zero_q <= ~|gen_stage[NBLK-1].word_d;
        end
    end

    // Overflow comes from registered bits only, so it reads 0 after reset like the other flags.
    assign ovf  = (gen_stage[NBLK-1].flg_q.a_msb == gen_stage[NBLK-1].flg_q.b_msb) &&
                  (sum[WIDTH-1] != gen_stage[NBLK-1].flg_q.a_msb);
    assign zero = zero_q;
`else
    assign ovf  = 1'b0;
    assign zero = 1'b0;
`endif

endmodule

// File: tb/tb_pipelined_csel_adder.sv
// Self-checking bench for pipelined_csel_adder: directed vectors, stall/ordering, reset flush, random stream.
// Honours CSEL_ADDER_FLAGS_EN the same way as the design (flags expected 0 when undefined).
module tb_pipelined_csel_adder;

    localparam int W    = 16;
    localparam int BLK  = 4;
    localparam int NBLK = W / BLK;
    localparam int EW   = W + 3;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         sub = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         zero;

    int            checks   = 0;
    int            failures = 0;
    int            rx_count = 0;
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] obs;
    logic          prev_stall = 1'b0;
    logic [EW-1:0] prev_obs   = '0;

    assign obs = {sum, cout, ovf, zero};

    pipelined_csel_adder #(.WIDTH(W), .BLK(BLK)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .sub      (sub),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum),
        .cout     (cout),
        .ovf      (ovf),
        .zero     (zero)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic flag_exp(input logic f);
`ifdef CSEL_ADDER_FLAGS_EN
        return f;
`else
        return 1'b0 & f;
`endif
    endfunction

    // Reference: sum = a + (b ^ {W{sub}}) + (cin ^ sub), flags from the operand/result MSBs.
    function automatic logic [EW-1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                            input logic mcin, input logic msub);
        logic [W-1:0] be;
        logic [W:0]   full;
        logic         o;
        logic         z;
        be   = mb ^ {W{msub}};
        full = {1'b0, ma} + {1'b0, be} + {{W{1'b0}}, mcin ^ msub};
        o    = (ma[W-1] == be[W-1]) && (full[W-1] != ma[W-1]);
        z    = (full[W-1:0] == '0);
        return {full[W-1:0], full[W], flag_exp(o), flag_exp(z)};
    endfunction

    // ---------------- scoreboard monitor (samples on negedge) ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("hold_valid", 32'(out_valid), 32'd1);
                    check("hold_data", 32'(obs), 32'(prev_obs));
                end
                if (out_valid && out_ready) begin
                    check("out_has_expected", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) check("result", 32'(obs), 32'(exp_q.pop_front()));
                    rx_count++;
                end
                if (in_valid && in_ready) exp_q.push_back(model(a, b, cin, sub));
                prev_stall = out_valid && !out_ready;
                prev_obs   = obs;
            end
        end
    end

    // ---------------- drivers ----------------
    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            2:       return {1'b0, {(W-1){1'b1}}};
            3:       return {1'b1, {(W-1){1'b0}}};
            default: return W'($urandom);
        endcase
    endfunction

    task automatic drive_random();
        a        = pick();
        b        = pick();
        cin      = 1'($urandom_range(0, 1));
        sub      = 1'($urandom_range(0, 1));
        in_valid = 1'b1;
    endtask

    task automatic directed(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb,
                            input logic tcin, input logic tsub, input logic [W-1:0] esum,
                            input logic ecout, input logic eovf, input logic ezero);
        int cyc;
        out_ready = 1'b1;
        a = ta; b = tb; cin = tcin; sub = tsub; in_valid = 1'b1;
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        cyc = 1;
        while (!out_valid && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        check({tag, "_latency"}, 32'(cyc), 32'(NBLK));
        check({tag, "_sum"}, 32'(sum), 32'(esum));
        check({tag, "_cout"}, 32'(cout), 32'(ecout));
        check({tag, "_ovf"}, 32'(ovf), 32'(flag_exp(eovf)));
        check({tag, "_zero"}, 32'(zero), 32'(flag_exp(ezero)));
    endtask

    task automatic stream(input int n, input int stall_len, input bit rand_flow, output int cycles);
        int sent       = 0;
        int cyc        = 0;
        int stall_left = 0;
        int rx_start   = rx_count;
        int budget     = n * 6 + 200;
        bit stalled    = 1'b0;
        bit acc;
        out_ready = 1'b1;
        in_valid  = 1'b0;
        while ((sent < n || exp_q.size() != 0) && cyc < budget) begin
            if (!in_valid && sent < n && (!rand_flow || $urandom_range(0, 3) != 0)) drive_random();
            @(negedge clk);
            acc = in_valid && in_ready;
            if (stall_left > 0) check("stall_in_ready", 32'(in_ready), 32'd0);
            @(posedge clk); #1;
            cyc++;
            if (acc) begin
                sent++;
                in_valid = 1'b0;
            end
            if (stall_left > 0) stall_left--;
            if (stall_len > 0 && !stalled && out_valid) begin
                stalled    = 1'b1;
                stall_left = stall_len;
            end
            if (stall_left > 0)  out_ready = 1'b0;
            else if (rand_flow)  out_ready = ($urandom_range(0, 3) != 0);
            else                 out_ready = 1'b1;
        end
        check("stream_in_budget", 32'(cyc < budget), 32'd1);
        check("stream_beats_out", 32'(rx_count - rx_start), 32'(n));
        check("stream_queue_empty", 32'(exp_q.size()), 32'd0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        cycles    = cyc;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int cycles;
        int seen;

        #2;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        check("rst_zero", 32'(zero), 32'd0);
        #10 rst = 1'b0;
        @(posedge clk); #1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        directed("add_carry",  16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0);
        directed("full_carry", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        directed("add_ovf",    16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
        directed("sub",        16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
        directed("sub_ovf",    16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);
        directed("sub_borrow", 16'h0010, 16'h0003, 1'b1, 1'b1, 16'h000C, 1'b1, 1'b0, 1'b0);
        @(posedge clk); #1;

        // Back-to-back full rate: n beats drain in exactly n + NBLK cycles.
        stream(20, 0, 1'b0, cycles);
        check("full_rate_cycles", 32'(cycles), 32'(20 + NBLK));

        // Six beats with a three-cycle output stall once the first result appears.
        stream(6, 3, 1'b0, cycles);

        // Reset with three beats in flight.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_random();
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        seen = 0;
        while (!out_valid && seen < 10) begin
            @(posedge clk); #1;
            seen++;
        end
        check("flush_pipe_filled", 32'(out_valid), 32'd1);
        #1 rst = 1'b1;
        #1;
        check("flush_out_valid", 32'(out_valid), 32'd0);
        check("flush_sum", 32'(sum), 32'd0);
        check("flush_cout", 32'(cout), 32'd0);
        exp_q.delete();
        @(negedge clk); #2 rst = 1'b0;
        @(posedge clk); #1;
        check("flush_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        check("flush_no_stale", 32'(seen), 32'd0);

        // Random mixed add/sub stream with random bubbles and back-pressure.
        stream(10000, 0, 1'b1, cycles);

        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
